// File: rtl/alu_pkg.sv
// Shared ALU control-code definitions used by the control decoder and alu_seq.
package alu_pkg;

  localparam int unsigned ALU_DATA_W = 32;
  localparam int unsigned MUL_ITERS  = 32;
  localparam int unsigned MUL_CNT_W  = 5;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_MUL  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SLLV = 4'b1001;
  localparam logic [3:0] ALU_LUI  = 4'b1010;
  localparam logic [3:0] ALU_BNE  = 4'b1011;

  // True for every code the execution unit implements.
  function automatic logic alu_code_legal(input logic [3:0] code);
    logic legal;
    case (code)
      ALU_AND, ALU_OR, ALU_ADD, ALU_MUL, ALU_SUB, ALU_SLT,
      ALU_SLTU, ALU_SLL, ALU_SLLV, ALU_LUI, ALU_BNE: legal = 1'b1;
      default:                                       legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier datapath: one partial product per step.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = ALU_DATA_W,
  parameter int unsigned CNT_W  = MUL_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              go,
  input  logic              step,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              last,
  output logic [DATA_W-1:0] product
);

  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] mplier_sh;
  logic [DATA_W-1:0] mcand_sh;
  logic [CNT_W-1:0]  cnt;

  // Accumulator value after the current step; on the last step this is the product.
  assign product = mcand_sh[0] ? (acc + mplier_sh) : acc;
  assign last    = step && (cnt == CNT_W'(MUL_ITERS - 1));

  // Load operands on go, then add/shift/count once per step.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc       <= '0;
      mplier_sh <= '0;
      mcand_sh  <= '0;
      cnt       <= '0;
    end else if (go) begin
      acc       <= '0;
      mplier_sh <= a;
      mcand_sh  <= b;
      cnt       <= '0;
    end else if (step) begin
      acc       <= product;
      mplier_sh <= mplier_sh << 1;
      mcand_sh  <= mcand_sh >> 1;
      cnt       <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// EX-stage execution unit: registered single-cycle ops plus an iterative multiply.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = ALU_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [3:0]        ctrl_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  input  logic [4:0]        shamt_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              illegal_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  logic [0:0]        state;
  logic [DATA_W-1:0] op_res;
  logic              op_zero;
  logic              op_illegal;
  logic              mul_go;
  logic              mul_step;
  logic              mul_last;
  logic [DATA_W-1:0] mul_product;

  assign busy_o   = (state == ST_MUL);
  assign mul_go   = (state == ST_IDLE) && start_i && (ctrl_i == ALU_MUL);
  assign mul_step = (state == ST_MUL);

  alu_mul_iter #(
    .DATA_W (DATA_W),
    .CNT_W  (MUL_CNT_W)
  ) u_mul (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .go      (mul_go),
    .step    (mul_step),
    .a       (src1_i),
    .b       (src2_i),
    .last    (mul_last),
    .product (mul_product)
  );

  // Single-cycle result and branch flag for the code presented at issue.
  always_comb begin
    op_res     = '0;
    op_illegal = !alu_code_legal(ctrl_i);
    case (ctrl_i)
      ALU_AND:          op_res = src1_i & src2_i;
      ALU_OR:           op_res = src1_i | src2_i;
      ALU_ADD:          op_res = src1_i + src2_i;
      ALU_SUB, ALU_BNE: op_res = src1_i - src2_i;
      ALU_SLT:          op_res = {{(DATA_W-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
      ALU_SLTU:         op_res = {{(DATA_W-1){1'b0}}, (src1_i < src2_i)};
      ALU_SLL:          op_res = src2_i << shamt_i;
      ALU_SLLV:         op_res = src2_i << src1_i[4:0];
      ALU_LUI:          op_res = src2_i << 16;
      default:          op_res = '0;
    endcase
    // bne inverts the flag so downstream always reads it as "take branch".
    op_zero = (ctrl_i == ALU_BNE) ? (op_res != '0) : (op_res == '0);
  end

  // Issue/complete control and the registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      done_o    <= 1'b0;
      illegal_o <= 1'b0;
      result_o  <= '0;
      zero_o    <= 1'b0;
    end else begin
      done_o    <= 1'b0;
      illegal_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            if (ctrl_i == ALU_MUL) begin
              state <= ST_MUL;
            end else begin
              result_o  <= op_res;
              zero_o    <= op_zero;
              illegal_o <= op_illegal;
              done_o    <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (mul_last) begin
            result_o <= mul_product;
            zero_o   <= (mul_product == '0);
            done_o   <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq against a behavioural reference model.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  ctrl = 4'b0000;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic [4:0]  shamt = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  alu_seq #(.DATA_W(32)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .ctrl_i    (ctrl),
    .src1_i    (src1),
    .src2_i    (src2),
    .shamt_i   (shamt),
    .busy_o    (busy),
    .done_o    (done),
    .result_o  (result),
    .zero_o    (zero),
    .illegal_o (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Reference: result, flag and legality straight from the code table.
  function automatic void ref_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sh, output logic [31:0] r, output logic z,
                                 output logic il);
    logic [63:0] p;
    r  = 32'd0;
    il = 1'b0;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0011: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
      4'b0110: r = a - b;
      4'b1011: r = a - b;
      4'b0111: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'b1111: r = (a < b) ? 32'd1 : 32'd0;
      4'b1000: r = b * (32'd1 << sh);
      4'b1001: r = b * (32'd1 << a[4:0]);
      4'b1010: r = {b[15:0], 16'h0000};
      default: il = 1'b1;
    endcase
    z = (c == 4'b1011) ? (r != 32'd0) : (r == 32'd0);
  endfunction

  // Present one issue for a single edge and sample 1 ns after it.
  task automatic issue_one(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh);
    @(negedge clk);
    start = 1'b1; ctrl = c; src1 = a; src2 = b; shamt = sh;
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  // After a mul issue: step until done, optionally pulsing an add at step add_at.
  task automatic wait_mul(input int add_at, output int done_at, output int busy_n);
    done_at = -1;
    busy_n  = (busy === 1'b1) ? 1 : 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == add_at) begin
        start = 1'b1; ctrl = 4'b0010; src1 = 32'd1; src2 = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done === 1'b1) begin
        done_at = k;
        break;
      end
      if (busy === 1'b1) busy_n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || illegal !== 1'b0 || result !== 32'd0 || zero !== 1'b0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b illegal=%b result=%h zero=%b, required 0 0 0 00000000 0",
               busy, done, illegal, result, zero);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: done=%b busy=%b, required 0 0", done, busy);
    end
  endtask

  task automatic test_directed();
    logic [3:0]  c [9]  = '{4'b0010, 4'b0110, 4'b0110, 4'b1011, 4'b0111, 4'b1111, 4'b1000, 4'b1010, 4'b1001};
    logic [31:0] a [9]  = '{32'h7FFFFFFF, 32'd5, 32'd9, 32'd9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd4};
    logic [31:0] b [9]  = '{32'd1, 32'd7, 32'd9, 32'd9, 32'd1, 32'd1, 32'd1, 32'h1234, 32'h3};
    logic [4:0]  sh [9] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd0, 5'd0};
    logic [31:0] er [9] = '{32'h80000000, 32'hFFFFFFFE, 32'd0, 32'd0, 32'd1, 32'd0, 32'h80000000, 32'h12340000, 32'h30};
    logic        ez [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      issue_one(c[i], a[i], b[i], sh[i]);
      checks++;
      if (done !== 1'b1 || result !== er[i] || zero !== ez[i] || illegal !== 1'b0) begin
        errors++;
        $display("FAIL directed[%0d] code=%b: done=%b result=%h zero=%b illegal=%b, required 1 %h %b 0",
                 i, c[i], done, result, zero, illegal, er[i], ez[i]);
      end
    end
    idle_cycle();
    checks++;
    if (done !== 1'b0 || result !== er[8]) begin
      errors++;
      $display("FAIL done_single_pulse: done=%b result=%h, required 0 %h", done, result, er[8]);
    end
  endtask

  task automatic test_mul();
    int done_at;
    int busy_n;
    issue_one(4'b0011, 32'd7, 32'hFFFFFFFD, 5'd0);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL mul_issue: busy=%b done=%b, required 1 0", busy, done);
    end
    wait_mul(5, done_at, busy_n);
    checks++;
    if (done_at !== 32 || busy_n !== 32) begin
      errors++;
      $display("FAIL mul_timing: done_at=%0d busy_cycles=%0d, required 32 32", done_at, busy_n);
    end
    checks++;
    if (result !== 32'hFFFFFFEB || zero !== 1'b0 || busy !== 1'b0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL mul_result: result=%h zero=%b busy=%b illegal=%b, required ffffffeb 0 0 0",
               result, zero, busy, illegal);
    end
    issue_one(4'b0010, 32'd1, 32'd1, 5'd0);
    checks++;
    if (done !== 1'b1 || result !== 32'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL add_after_mul: done=%b result=%h busy=%b, required 1 00000002 0", done, result, busy);
    end
    idle_cycle();
  endtask

  task automatic test_mul_reset();
    int done_at;
    int busy_n;
    int late_done;
    issue_one(4'b0011, 32'h00010001, 32'h00010001, 5'd0);
    wait_mul(0, done_at, busy_n);
    checks++;
    if (done_at !== 32 || result !== 32'h00020001 || zero !== 1'b0) begin
      errors++;
      $display("FAIL mul_0x10001: done_at=%0d result=%h zero=%b, required 32 00020001 0", done_at, result, zero);
    end
    issue_one(4'b0011, 32'h12345678, 32'h9ABCDEF1, 5'd0);
    for (int k = 1; k < 10; k++) idle_cycle();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || result !== 32'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mul_abort: busy=%b result=%h done=%b, required 0 00000000 0", busy, result, done);
    end
    @(negedge clk);
    rst = 1'b0;
    late_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) late_done++;
    end
    checks++;
    if (late_done !== 0) begin
      errors++;
      $display("FAIL mul_abort_quiet: done/busy cycles=%0d, required 0", late_done);
    end
  endtask

  task automatic test_illegal();
    logic [3:0] codes [5] = '{4'b0100, 4'b0101, 4'b1100, 4'b1101, 4'b1110};
    for (int i = 0; i < 5; i++) begin
      issue_one(codes[i], $urandom, $urandom, 5'($urandom));
      checks++;
      if (done !== 1'b1 || illegal !== 1'b1 || result !== 32'd0 || zero !== 1'b1) begin
        errors++;
        $display("FAIL illegal[%b]: done=%b illegal=%b result=%h zero=%b, required 1 1 00000000 1",
                 codes[i], done, illegal, result, zero);
      end
    end
    idle_cycle();
    checks++;
    if (done !== 1'b0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_pulse: done=%b illegal=%b, required 0 0", done, illegal);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  c;
    logic [31:0] a, b, er;
    logic [4:0]  sh;
    logic        ez, ei;
    for (int i = 0; i < 80; i++) begin
      c = 4'($urandom_range(0, 15));
      if (c == 4'b0011) c = 4'b0110;
      a  = (i % 4 == 0) ? b : $urandom;
      b  = (i % 7 == 0) ? a : $urandom;
      sh = 5'($urandom);
      ref_op(c, a, b, sh, er, ez, ei);
      issue_one(c, a, b, sh);
      checks++;
      if (done !== 1'b1 || result !== er || zero !== ez || illegal !== ei) begin
        errors++;
        $display("FAIL b2b[%0d] code=%b a=%h b=%h sh=%0d: done=%b result=%h zero=%b illegal=%b, required 1 %h %b %b",
                 i, c, a, b, sh, done, result, zero, illegal, er, ez, ei);
      end
    end
    idle_cycle();
  endtask

  task automatic test_random_mul();
    logic [31:0] a, b, er;
    logic        ez, ei;
    int          done_at;
    int          busy_n;
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = (i == 0) ? 32'd0 : $urandom;
      ref_op(4'b0011, a, b, 5'd0, er, ez, ei);
      issue_one(4'b0011, a, b, 5'd0);
      wait_mul(0, done_at, busy_n);
      checks++;
      if (done_at !== 32 || busy_n !== 32 || result !== er || zero !== ez || illegal !== ei) begin
        errors++;
        $display("FAIL rand_mul[%0d] a=%h b=%h: done_at=%0d busy=%0d result=%h zero=%b, required 32 32 %h %b",
                 i, a, b, done_at, busy_n, result, zero, er, ez);
      end
    end
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mul();
    test_mul_reset();
    test_illegal();
    test_back_to_back();
    test_random_mul();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
